// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state and op-class predicates for the iterative MDU.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Latched context of the in-flight iterative op.
  typedef struct packed {
    logic [3:0] op;
    logic       neg_lo;   // negate product / quotient at the end
    logic       neg_hi;   // negate remainder at the end
  } op_ctx_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the remainder, trial-subtract the divisor, emit one quotient bit.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, divisor};
  // When ge holds the difference is below the divisor, so WIDTH bits suffice.
  assign diff    = shifted[WIDTH-1:0] - divisor;
  assign rem_nxt = ge ? diff : shifted[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one bit per cycle,
// WIDTH cycles per op. MDU_MADD_EN enables the multiply-accumulate ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W2:0]     acc, acc_nxt;
  logic [WIDTH:0]  opnd;
  op_ctx_t         ctx;

  logic            accept_iter, accept_mt, last;
  logic            sa, sb, in_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]  mul_sum;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [W2-1:0]   mul_res, div_res, result;

  assign accept_iter = (state == IDLE) && start && !flush && is_iter_op(op);
  assign accept_mt   = (state == IDLE) && start && !flush && ((op == OP_MTHI) || (op == OP_MTLO));
  assign last        = (state == RUN) && !flush && (cnt == CW'(1));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_iter) state_nxt = RUN;
      RUN:  if (flush || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN);
  end

  // Operand conditioning; magnitudes of the most-negative value stay exact as unsigned.
  assign in_div = is_div_op(op);
  assign sa     = is_signed_op(op) & a[WIDTH-1];
  assign sb     = is_signed_op(op) & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  // Multiply step: acc = {partial[WIDTH:0], multiplier[WIDTH-1:0]}, shift right each cycle.
  assign mul_sum = acc[W2:WIDTH] + (acc[0] ? opnd : '0);

  // Divide step: acc = {rem, quotient/dividend}.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc[W2-1:WIDTH]),
    .quo     (acc[WIDTH-1:0]),
    .divisor (opnd[WIDTH-1:0]),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    if (is_div_op(ctx.op)) acc_nxt = {1'b0, rem_nxt, quo_nxt};
    else                   acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  // Sign fixup on the final step's value.
  always_comb begin
    mul_res = ctx.neg_lo ? -acc_nxt[W2-1:0] : acc_nxt[W2-1:0];
    div_res = {(ctx.neg_hi ? -rem_nxt : rem_nxt), (ctx.neg_lo ? -quo_nxt : quo_nxt)};
    result  = is_div_op(ctx.op) ? div_res : mul_res;
`ifdef MDU_MADD_EN
    if (is_acc_op(ctx.op))
      result = is_sub_op(ctx.op) ? ({hi, lo} - mul_res) : ({hi, lo} + mul_res);
`endif
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
      ctx  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (accept_iter) begin
        cnt        <= CW'(WIDTH);
        ctx.op     <= op;
        // Divide by zero: quotient stays all ones and the remainder rebuilds a.
        ctx.neg_lo <= (sa ^ sb) & ~(in_div & (b == '0));
        ctx.neg_hi <= in_div & sa;
        if (in_div) begin
          acc  <= {{(WIDTH+1){1'b0}}, mag_a};
          opnd <= {1'b0, mag_b};
        end else begin
          acc  <= {{(WIDTH+1){1'b0}}, mag_b};
          opnd <= {1'b0, mag_a};
        end
      end else if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= flush ? '0 : cnt - CW'(1);
      end
      if (accept_mt) begin
        if (op == OP_MTHI) hi <= a;
        else               lo <= a;
      end
      if (last) begin
        hi <= result[W2-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_hilo = '0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [63:0] exp, input string tag);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        if (i == 16) chk({tag, " hold"}, {hi, lo}, exp_hilo);
        @(negedge clk);
      end
    end
    chk({tag, " done"}, 64'(seen), 64'd1);
    chk({tag, " busy cycles"}, 64'(nb), 64'd32);
    chk({tag, " result"}, {hi, lo}, exp);
    exp_hilo = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy, seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, "mult");
    @(negedge clk);
    chk("done pulse width", 64'(done), 64'd0);
    run_op(OP_MULTU, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1, "multu");
    run_op(OP_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult minneg sq");
    run_op(OP_MULT, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000, "mult minneg x1");
    run_op(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "divu");
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div neg dividend");
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div neg divisor");
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div overflow");
    run_op(OP_DIVU, 32'd123, 32'd0, {32'd123, 32'hFFFFFFFF}, "divu by zero");
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, "div by zero");

    // MTHI/MTLO on consecutive cycles
    saw_busy = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hDEAD0000;
    @(negedge clk); saw_busy |= busy;
    chk("mthi", 64'(hi), 64'hDEAD0000);
    op = OP_MTLO; a = 32'h0000BEEF;
    @(negedge clk); saw_busy |= busy;
    chk("mtlo", 64'(lo), 64'h0000BEEF);
    start = 1'b0;
    @(negedge clk); saw_busy |= busy;
    chk("mt never busy", 64'(saw_busy), 64'd0);
    exp_hilo = {32'hDEAD0000, 32'h0000BEEF};

    // flush with start in IDLE: flush wins
    start = 1'b1; op = OP_MTHI; a = 32'h11111111; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("idle flush wins", {hi, lo}, exp_hilo);

    // undefined op ignored
    start = 1'b1; op = 4'd6; a = 32'h22222222; b = 32'd3;
    @(negedge clk); start = 1'b0;
    chk("undef op busy", 64'(busy), 64'd0);
    chk("undef op hilo", {hi, lo}, exp_hilo);

    // MULT, MTLO ignored while busy, then flush
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'h12345678;
    @(negedge clk); start = 1'b0;
    chk("mtlo while busy: busy", 64'(busy), 64'd1);
    chk("mtlo while busy: hilo", {hi, lo}, exp_hilo);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hilo", {hi, lo}, exp_hilo);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush hilo later", {hi, lo}, exp_hilo);

`ifdef MDU_MADD_EN
    start = 1'b1; op = OP_MTHI; a = 32'd0;
    @(negedge clk); op = OP_MTLO; a = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0;
    exp_hilo = {32'd0, 32'hFFFFFFFF};
    chk("madd preload", {hi, lo}, exp_hilo);
    run_op(OP_MADDU, 32'd1, 32'd1, {32'd1, 32'd0}, "maddu");
    @(negedge clk);
    run_op(OP_MSUB, 32'd1, 32'd2, {32'd0, 32'hFFFFFFFE}, "msub");
    @(negedge clk);
`else
    start = 1'b1; op = OP_MADD; a = 32'd1; b = 32'd1;
    @(negedge clk); start = 1'b0;
    chk("madd undef busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("madd undef busy later", 64'(busy), 64'd0);
    chk("madd undef hilo", {hi, lo}, exp_hilo);
`endif

    // async reset mid-RUN
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst hilo", {hi, lo}, 64'd0);
    exp_hilo = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // back-to-back: second op issued in the done cycle
    run_op(OP_MULTU, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1, "b2b first");
    run_op(OP_MULTU, 32'd2, 32'd3, 64'd6, "b2b second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
